bin_to_bcd_seq: RTL

Sequential, parametrised binary-to-BCD converter using shift-and-add-3 (double dabble), one shift per clock. It accepts unsigned or two's-complement input via a start/done handshake. Outputs are BCD digits, sign, overflow and a leading-zero mask. It sits between the arithmetic datapath and the seven-segment display driver, and replaces the purely combinational converters where width or area grows.

---
 rtl/bin_to_bcd_seq.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
// Accepts unsigned or two's-complement operands; reports sign, overflow and leading-zero mask.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf,
    output logic [DIGITS-1:0]     lz
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [DIGITS-1:0] LZ_RST = ~DIGITS'(1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   scr_q, scr_d;
    logic               sticky_q, sticky_d;
    logic               sign_q, sign_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               neg_q, neg_d;
    logic               ovf_q, ovf_d;
    logic [DIGITS-1:0]  lz_q, lz_d;
    logic               done_q, done_d;

    logic               last;
    logic [BIN_W-1:0]   mag;
    logic [BCD_W-1:0]   adj;
    logic [BCD_W-1:0]   fin;
    logic               carry;
    logic               zacc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            scr_q    <= '0;
            sticky_q <= 1'b0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            lz_q     <= LZ_RST;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            scr_q    <= scr_d;
            sticky_q <= sticky_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            lz_q     <= lz_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        last    = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // Two's-complement negate in BIN_W bits keeps -2^(BIN_W-1) exact as 2^(BIN_W-1).
        mag = bin;
        if (is_signed && bin[BIN_W-1]) mag = ~bin + BIN_W'(1);

        for (int unsigned i = 0; i < DIGITS; i++) begin
            adj[4*i +: 4] = (scr_q[4*i +: 4] > 4'd4) ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        end
        {carry, fin} = {adj, bin_q[BIN_W-1]};

        zacc = 1'b1;
        lz_d = lz_q;

        bin_d    = bin_q;
        scr_d    = scr_q;
        sticky_d = sticky_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;

        if (state_q == IDLE && start) begin
            bin_d    = mag;
            scr_d    = '0;
            sticky_d = 1'b0;
            sign_d   = is_signed & bin[BIN_W-1];
            cnt_d    = CNT_W'(BIN_W);
        end else if (state_q == SHIFT) begin
            bin_d    = {bin_q[BIN_W-2:0], 1'b0};
            scr_d    = fin;
            sticky_d = sticky_q | carry;
            cnt_d    = cnt_q - CNT_W'(1);
            if (last) begin
                bcd_d  = fin;
                neg_d  = sign_q;
                ovf_d  = sticky_q | carry;
                done_d = 1'b1;
                for (int unsigned k = 0; k < DIGITS; k++) begin
                    zacc = zacc & (fin[4*(DIGITS-1-k) +: 4] == 4'd0);
                    lz_d[DIGITS-1-k] = zacc;
                end
                lz_d[0] = 1'b0;
            end
        end
    end

    always_comb begin
        busy = (state_q == SHIFT);
        done = done_q;
        bcd  = bcd_q;
        neg  = neg_q;
        ovf  = ovf_q;
        lz   = lz_q;
    end

endmodule
